// File: rtl/fetch_unit_if.sv
// Blimp fetch unit bundle: instruction memory request/response,
// decode delivery and downstream redirect, grouped for one port.
interface fetch_unit_if #(
    parameter int p_opaq_bits = 8
);
    logic                   mem_req_val;
    logic                   mem_req_rdy;
    logic [3:0]             mem_req_op;
    logic [p_opaq_bits-1:0] mem_req_opaque;
    logic [31:0]            mem_req_addr;
    logic [1:0]             mem_req_len;
    logic [31:0]            mem_req_data;

    logic                   mem_resp_val;
    logic                   mem_resp_rdy;
    logic [p_opaq_bits-1:0] mem_resp_opaque;
    logic [31:0]            mem_resp_addr;
    logic [31:0]            mem_resp_data;

    logic                   D_val;
    logic                   D_rdy;
    logic [31:0]            D_pc;
    logic [31:0]            D_inst;

    logic                   squash_val;
    logic [31:0]            squash_target;

    modport master (
        output mem_req_val, mem_req_op, mem_req_opaque,
        output mem_req_addr, mem_req_len, mem_req_data,
        input  mem_req_rdy,
        input  mem_resp_val, mem_resp_opaque,
        input  mem_resp_addr, mem_resp_data,
        output mem_resp_rdy,
        output D_val, D_pc, D_inst,
        input  D_rdy,
        input  squash_val, squash_target
    );

    modport slave (
        input  mem_req_val, mem_req_op, mem_req_opaque,
        input  mem_req_addr, mem_req_len, mem_req_data,
        output mem_req_rdy,
        output mem_resp_val, mem_resp_opaque,
        output mem_resp_addr, mem_resp_data,
        input  mem_resp_rdy,
        input  D_val, D_pc, D_inst,
        output D_rdy,
        output squash_val, squash_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Blimp instruction fetch front end: sequential PC generation,
// epoch-tagged pipelined memory reads, registered decode output.
module fetch_unit #(
    parameter int          p_opaq_bits     = 8,
    parameter logic [31:0] p_rst_addr      = 32'h0000_0200,
    parameter int          p_max_in_flight = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    typedef enum logic {
        S_FETCH,
        S_DRAIN
    } state_e;

    localparam logic [3:0] MaxInFlight = 4'(p_max_in_flight);

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [p_opaq_bits-1:0] epoch_q, epoch_d;
    logic [3:0]             inflight_q, inflight_d;
    logic                   dval_q, dval_d;
    logic [31:0]            dpc_q, dpc_d;
    logic [31:0]            dinst_q, dinst_d;

    logic req_val;
    logic req_fire;
    logic stale;
    logic resp_rdy;
    logic resp_fire;
    logic fresh_fire;
    logic d_val;
    logic xfer;

    // Handshake decode; a squash kills requests and delivery this cycle
    always_comb begin
        req_val    = rst & ~bus.squash_val & (state_q == S_FETCH)
                   & (inflight_q < MaxInFlight);
        req_fire   = req_val & bus.mem_req_rdy;
        stale      = (bus.mem_resp_opaque != epoch_q) | bus.squash_val;
        resp_rdy   = stale | ~dval_q | bus.D_rdy;
        resp_fire  = bus.mem_resp_val & resp_rdy;
        fresh_fire = resp_fire & ~stale;
        d_val      = dval_q & ~bus.squash_val;
        xfer       = d_val & bus.D_rdy;
    end

    assign bus.mem_req_val    = req_val;
    assign bus.mem_req_op     = 4'd0;
    assign bus.mem_req_opaque = epoch_q;
    assign bus.mem_req_addr   = pc_q;
    assign bus.mem_req_len    = 2'd0;
    assign bus.mem_req_data   = 32'd0;
    assign bus.mem_resp_rdy   = resp_rdy;
    assign bus.D_val          = d_val;
    assign bus.D_pc           = dpc_q;
    assign bus.D_inst         = dinst_q;

    // Next state: squash overrides all; drain blocks issue until the
    // old epoch's requests are gone, so epochs can never alias
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        dval_d     = dval_q;
        dpc_d      = dpc_q;
        dinst_d    = dinst_q;
        inflight_d = inflight_q + {3'd0, req_fire} - {3'd0, resp_fire};
        if (bus.squash_val) begin
            pc_d    = bus.squash_target;
            epoch_d = epoch_q + p_opaq_bits'(1);
            dval_d  = 1'b0;
            state_d = (inflight_d != 4'd0) ? S_DRAIN : S_FETCH;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (fresh_fire) begin
                dval_d  = 1'b1;
                dpc_d   = bus.mem_resp_addr;
                dinst_d = bus.mem_resp_data;
            end else if (xfer) begin
                dval_d = 1'b0;
            end
            if (state_q == S_DRAIN && inflight_q == 4'd0) begin
                state_d = S_FETCH;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            pc_q       <= p_rst_addr;
            epoch_q    <= '0;
            inflight_q <= 4'd0;
            dval_q     <= 1'b0;
            dpc_q      <= 32'd0;
            dinst_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            inflight_q <= inflight_d;
            dval_q     <= dval_d;
            dpc_q      <= dpc_d;
            dinst_q    <= dinst_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-vector bench for fetch_unit (2-bit epoch so the
// wrap is reachable), plus a squash-storm sequence.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct {
        logic        rst;
        logic        rqr;
        logic        rsv;
        logic [1:0]  rso;
        logic [31:0] rsa;
        logic        drdy;
        logic        sq;
        logic [31:0] tgt;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic [1:0]  e_op;
        logic        e_rsr;
        logic        e_dv;
        logic [31:0] e_pc;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[29];

    fetch_unit_if #(.p_opaq_bits(2)) bus ();

    fetch_unit #(
        .p_opaq_bits(2),
        .p_rst_addr(32'h0000_0200),
        .p_max_in_flight(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        int rst_v, int rqr, int rsv, int rso, int rsa, int drdy,
        int sq, int tgt, int e_rqv, int e_addr, int e_op,
        int e_rsr, int e_dv, int e_pc
    );
        vec_t v;
        v.rst    = (rst_v != 0);
        v.rqr    = (rqr != 0);
        v.rsv    = (rsv != 0);
        v.rso    = 2'(rso);
        v.rsa    = 32'(rsa);
        v.drdy   = (drdy != 0);
        v.sq     = (sq != 0);
        v.tgt    = 32'(tgt);
        v.e_rqv  = (e_rqv != 0);
        v.e_addr = 32'(e_addr);
        v.e_op   = 2'(e_op);
        v.e_rsr  = (e_rsr != 0);
        v.e_dv   = (e_dv != 0);
        v.e_pc   = 32'(e_pc);
        return v;
    endfunction

    task automatic chk(input int id, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h",
                     id, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        rst                 = v.rst;
        bus.mem_req_rdy     = v.rqr;
        bus.mem_resp_val    = v.rsv;
        bus.mem_resp_opaque = v.rso;
        bus.mem_resp_addr   = v.rsa;
        bus.mem_resp_data   = v.rsa ^ K;
        bus.D_rdy           = v.drdy;
        bus.squash_val      = v.sq;
        bus.squash_target   = v.tgt;
        #2;
        chk(id, "req_val", 32'(bus.mem_req_val), 32'(v.e_rqv));
        if (v.e_rqv) begin
            chk(id, "req_addr", bus.mem_req_addr, v.e_addr);
            chk(id, "req_opaque", 32'(bus.mem_req_opaque), 32'(v.e_op));
        end
        chk(id, "req_const",
            {bus.mem_req_op, bus.mem_req_len, bus.mem_req_data[25:0]},
            32'd0);
        chk(id, "resp_rdy", 32'(bus.mem_resp_rdy), 32'(v.e_rsr));
        chk(id, "D_val", 32'(bus.D_val), 32'(v.e_dv));
        if (v.e_dv) begin
            chk(id, "D_pc", bus.D_pc, v.e_pc);
            chk(id, "D_inst", bus.D_inst, v.e_pc ^ K);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        tbl[0]  = mk(0,0,0,0,0,0,0,0,         0,0,0,1,0,0);
        tbl[1]  = mk(1,1,0,0,0,1,0,0,         1,'h200,0,1,0,0);
        tbl[2]  = mk(1,1,1,0,'h200,1,0,0,     1,'h204,0,1,0,0);
        tbl[3]  = mk(1,1,1,0,'h204,1,0,0,     1,'h208,0,1,1,'h200);
        tbl[4]  = mk(1,0,1,0,'h208,0,0,0,     1,'h20C,0,0,1,'h204);
        tbl[5]  = mk(1,0,1,0,'h208,0,0,0,     1,'h20C,0,0,1,'h204);
        tbl[6]  = mk(1,0,1,0,'h208,1,0,0,     1,'h20C,0,1,1,'h204);
        tbl[7]  = mk(1,1,0,0,0,0,0,0,         1,'h20C,0,0,1,'h208);
        tbl[8]  = mk(1,1,0,0,0,0,0,0,         1,'h210,0,0,1,'h208);
        tbl[9]  = mk(1,1,0,0,0,0,0,0,         1,'h214,0,0,1,'h208);
        tbl[10] = mk(1,1,0,0,0,1,1,'h1000,    0,0,0,1,0,0);
        tbl[11] = mk(1,1,1,0,'h20C,1,0,0,     0,0,0,1,0,0);
        tbl[12] = mk(1,1,1,0,'h210,1,0,0,     0,0,0,1,0,0);
        tbl[13] = mk(1,1,1,0,'h214,1,0,0,     0,0,0,1,0,0);
        tbl[14] = mk(1,1,0,1,0,1,0,0,         0,0,0,1,0,0);
        tbl[15] = mk(1,1,0,1,0,1,0,0,         1,'h1000,1,1,0,0);
        tbl[16] = mk(1,0,1,1,'h1000,1,0,0,    1,'h1004,1,1,0,0);
        tbl[17] = mk(1,0,0,1,0,1,0,0,         1,'h1004,1,1,1,'h1000);
        tbl[18] = mk(1,0,0,1,0,1,0,0,         1,'h1004,1,1,0,0);
        tbl[19] = mk(1,1,0,1,0,1,0,0,         1,'h1004,1,1,0,0);
        tbl[20] = mk(1,1,0,1,0,1,0,0,         1,'h1008,1,1,0,0);
        tbl[21] = mk(0,1,0,1,0,1,0,0,         0,0,0,1,0,0);
        tbl[22] = mk(1,1,0,0,0,1,0,0,         1,'h200,0,1,0,0);
        tbl[23] = mk(1,1,0,0,0,1,0,0,         1,'h204,0,1,0,0);
        tbl[24] = mk(1,1,0,0,0,1,0,0,         1,'h208,0,1,0,0);
        tbl[25] = mk(1,1,0,0,0,1,0,0,         1,'h20C,0,1,0,0);
        tbl[26] = mk(1,1,0,0,0,1,0,0,         0,0,0,1,0,0);
        tbl[27] = mk(1,1,1,0,'h200,1,0,0,     0,0,0,1,0,0);
        tbl[28] = mk(1,1,0,0,0,1,0,0,         1,'h210,0,1,1,'h200);

        rst                 = 1'b0;
        bus.mem_req_rdy     = 1'b0;
        bus.mem_resp_val    = 1'b0;
        bus.mem_resp_opaque = 2'd0;
        bus.mem_resp_addr   = 32'd0;
        bus.mem_resp_data   = 32'd0;
        bus.D_rdy           = 1'b0;
        bus.squash_val      = 1'b0;
        bus.squash_target   = 32'd0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 29; i++) begin
            apply(tbl[i], i);
        end

        // Five back-to-back squashes with four old requests draining;
        // epoch walks 1,2,3,0,1 and every old response is dropped
        for (int k = 0; k < 5; k++) begin
            apply(mk(1, 1, (k < 4) ? 1 : 0, 0, 'h204 + 4 * k, 1,
                     1, 'h3000 + 16 * k, 0, 0, 0, 1, 0, 0), 100 + k);
        end
        apply(mk(1,1,0,1,0,1,0,0,         1,'h3040,1,1,0,0), 105);
        apply(mk(1,0,1,1,'h3040,1,0,0,    1,'h3044,1,1,0,0), 106);
        apply(mk(1,0,0,1,0,1,0,0,         1,'h3044,1,1,1,'h3040), 107);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
